// File: rtl/model_share_pkg.sv
// Shared types and helpers for the model_share arbiter slice.
// Optional build macro MODEL_SHARE_ARB_FIXED_PRIO_EN selects fixed priority.
package model_share_pkg;

    localparam int unsigned W_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Grant index width; never narrower than one bit.
    function automatic int unsigned grant_width(input int unsigned n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/model_share_rr_pick.sv
// Combinational winner selection: round-robin from ptr, or fixed lowest-index
// priority when MODEL_SHARE_ARB_FIXED_PRIO_EN is defined.
module model_share_rr_pick
    import model_share_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IW    = grant_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    index
);

    logic        found;
    int unsigned slot;

`ifdef MODEL_SHARE_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        slot   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && valid[k]) begin
                found     = 1'b1;
                slot      = k;
                winner[k] = 1'b1;
                index     = IW'(k);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        slot   = 0;
        // Walk upward from the pointer, wrapping past the top requester.
        for (int unsigned off = 0; off < N_REQ; off++) begin
            slot = (32'(ptr) + off) % N_REQ;
            if (!found && valid[slot]) begin
                found        = 1'b1;
                winner[slot] = 1'b1;
                index        = IW'(slot);
            end
        end
    end
`endif

endmodule

// File: rtl/model_share_arb.sv
// Shares one datapath unit among N_REQ requesters: accept, launch, wait, respond.
// Define MODEL_SHARE_ARB_FIXED_PRIO_EN for strict lowest-index priority.
module model_share_arb
    import model_share_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned W     = W_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*W-1:0]             req_a,
    input  logic [N_REQ*W-1:0]             req_b,
    output logic [N_REQ-1:0]               rsp_valid,
    input  logic [N_REQ-1:0]               rsp_ready,
    output logic [W-1:0]                   rsp_a,
    output logic [W-1:0]                   rsp_b,
    output logic                           u_start,
    output logic [W-1:0]                   u_i0,
    output logic [W-1:0]                   u_i1,
    input  logic [W-1:0]                   u_o0,
    input  logic [W-1:0]                   u_o1,
    input  logic                           u_done,
    output logic                           busy,
    output logic [grant_width(N_REQ)-1:0]  grant_id
);

    localparam int unsigned GW = grant_width(N_REQ);

    state_t           state;
    logic [GW-1:0]    ptr;
    logic [GW-1:0]    next_ptr;
    logic [GW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [W-1:0]     pick_a;
    logic [W-1:0]     pick_b;

    model_share_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (GW)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (ptr),
        .winner (pick_onehot),
        .index  (pick_idx)
    );

    assign pick_a   = req_a[32'(pick_idx)*W +: W];
    assign pick_b   = req_b[32'(pick_idx)*W +: W];
    assign next_ptr = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign u_start = (state == ISSUE);
    assign busy    = (state != IDLE);

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state == IDLE) begin
            req_ready = pick_onehot;
        end
        if (state == RESP) begin
            rsp_valid[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            u_i0     <= '0;
            u_i1     <= '0;
            rsp_a    <= '0;
            rsp_b    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Any valid bit means the picker has a winner, so this is the handshake.
                    if (|req_valid) begin
                        u_i0     <= pick_a;
                        u_i1     <= pick_b;
                        grant_id <= pick_idx;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (u_done) begin
                        rsp_a <= u_o0;
                        rsp_b <= u_o1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
`ifndef MODEL_SHARE_ARB_FIXED_PRIO_EN
                        ptr <= next_ptr;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
